bin_a_digitos: RTL and testbench

Converts a stored binary colour-channel value into the three 5-bit digit codes (units, tens, hundreds) used by the keypad/display path. It is the read-back counterpart of the digit-entry memory, which assembles keypad digits. This block takes a committed numeric value and produces the u/d/c codes the display multiplexer shows. Conversion is sequential double-dabble with a start/busy/done handshake and fixed latency.

---
 rtl/digitos_pkg.sv | 20 ++
 rtl/bcd_ajuste3.sv | 14 +
 rtl/bin_a_digitos.sv | 94 +++++++++
 tb/tb_bin_a_digitos.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/digitos_pkg.sv
// rtl/digitos_pkg.sv - shared digit-code constants and converter state encoding
package digitos_pkg;

    localparam int          DIG_W      = 5;
    localparam logic [4:0]  DIG_BLANCO = 5'd16;
    localparam logic [4:0]  DIG_ERROR  = 5'd17;
    localparam logic [9:0]  VALOR_MAX  = 10'd999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } estado_t;

    // Widens a BCD nibble into a displayable digit code.
    function automatic logic [DIG_W-1:0] nib_a_dig(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/bcd_ajuste3.sv
// rtl/bcd_ajuste3.sv - double-dabble correction cell: add 3 when the nibble is 5 or more
module bcd_ajuste3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule

// File: rtl/bin_a_digitos.sv
// rtl/bin_a_digitos.sv - sequential binary-to-digit-code converter (units, tens, hundreds)
import digitos_pkg::*;

module bin_a_digitos (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       valor,
    output logic             busy,
    output logic             done,
    output logic [DIG_W-1:0] u,
    output logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] c
);

    estado_t     r_estado;
    logic [9:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_u;
    logic [4:0]  r_d;
    logic [4:0]  r_c;

    logic [11:0] w_bcd_adj;

    bcd_ajuste3 u_adj_u (.i_nib(r_bcd[3:0]),  .o_nib(w_bcd_adj[3:0]));
    bcd_ajuste3 u_adj_d (.i_nib(r_bcd[7:4]),  .o_nib(w_bcd_adj[7:4]));
    bcd_ajuste3 u_adj_c (.i_nib(r_bcd[11:8]), .o_nib(w_bcd_adj[11:8]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= ST_IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_u      <= DIG_BLANCO;
            r_d      <= DIG_BLANCO;
            r_c      <= DIG_BLANCO;
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    if (start) begin
                        r_bin    <= valor;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        // Overflow is judged on the binary input; BCD bits above 999 are lost.
                        r_err    <= (valor > VALOR_MAX);
                        r_busy   <= 1'b1;
                        r_estado <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_estado <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    if (r_err) begin
                        r_u <= DIG_ERROR;
                        r_d <= DIG_ERROR;
                        r_c <= DIG_ERROR;
                    end else begin
                        r_u <= nib_a_dig(r_bcd[3:0]);
                        r_d <= (r_bcd[11:4] == 8'd0) ? DIG_BLANCO : nib_a_dig(r_bcd[7:4]);
                        r_c <= (r_bcd[11:8] == 4'd0) ? DIG_BLANCO : nib_a_dig(r_bcd[11:8]);
                    end
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_estado <= ST_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign u    = r_u;
    assign d    = r_d;
    assign c    = r_c;

endmodule

// File: tb/tb_bin_a_digitos.sv
// tb/tb_bin_a_digitos.sv - randomized and directed check of bin_a_digitos against a decimal model
module tb_bin_a_digitos;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] valor;
    logic       busy;
    logic       done;
    logic [4:0] u;
    logic [4:0] d;
    logic [4:0] c;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: cycles left until done, the latched value, expected outputs.
    int       m_left = 0;
    int       m_val  = 0;
    bit       m_busy = 0;
    bit       m_done = 0;
    int       m_u = 16, m_d = 16, m_c = 16;

    bin_a_digitos dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .valor (valor),
        .busy  (busy),
        .done  (done),
        .u     (u),
        .d     (d),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fmt(input int v, output int fu, output int fd, output int fc);
        int h, t;
        if (v > 999) begin
            fu = 17; fd = 17; fc = 17;
        end else begin
            h  = v / 100;
            t  = (v / 10) % 10;
            fu = v % 10;
            fd = (h == 0 && t == 0) ? 16 : t;
            fc = (h == 0) ? 16 : h;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_busy = 0; m_done = 0;
            m_u = 16; m_d = 16; m_c = 16;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_busy = 0;
                    fmt(m_val, m_u, m_d, m_c);
                end
            end else if (start) begin
                m_val  = int'(valor);
                m_left = 11;
                m_busy = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done) done_cnt++;
        if (chk_en) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("u", int'(u), m_u);
            check("d", int'(d), m_d);
            check("c", int'(c), m_c);
        end
    end

    task automatic run_conv(input int v, input int ec, input int ed, input int eu);
        int n;
        @(negedge clk);
        start = 1'b1;
        valor = 10'(v);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("latency_%0d", v), n, 11);
        check($sformatf("c_%0d", v), int'(c), ec);
        check($sformatf("d_%0d", v), int'(d), ed);
        check($sformatf("u_%0d", v), int'(u), eu);
        @(negedge clk);
        check($sformatf("done_drop_%0d", v), int'(done), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; valor = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_u", int'(u), 16);
        check("rst_d", int'(d), 16);
        check("rst_c", int'(c), 16);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        run_conv(255, 2, 5, 5);
        run_conv(7, 16, 16, 7);
        run_conv(40, 16, 4, 0);
        run_conv(0, 16, 16, 0);
        run_conv(999, 9, 9, 9);
        run_conv(1000, 17, 17, 17);
        run_conv(1023, 17, 17, 17);
        run_conv(100, 1, 0, 0);

        // Ignored start mid-conversion, valor change, then back-to-back start.
        @(negedge clk);
        base = done_cnt;
        start = 1'b1; valor = 10'd123;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start = (i == 4);
            valor = (i == 4) ? 10'd456 : (i >= 6 ? 10'd777 : 10'd123);
        end
        start = 1'b0;
        @(negedge clk);
        check("seq_done", int'(done), 1);
        check("seq_c", int'(c), 1);
        check("seq_d", int'(d), 2);
        check("seq_u", int'(u), 3);
        check("seq_one_done", done_cnt - base, 1);
        start = 1'b1; valor = 10'd456;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        repeat (11) @(negedge clk);
        check("b2b_done", int'(done), 1);
        check("b2b_c", int'(c), 4);
        check("b2b_d", int'(d), 5);
        check("b2b_u", int'(u), 6);

        // Abort by reset, with a start on the reset edge.
        @(negedge clk);
        base = done_cnt;
        start = 1'b1; valor = 10'd888;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rst   = (i == 5);
            start = (i == 5);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_u", int'(u), 16);
        check("abort_c", int'(c), 16);
        repeat (15) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);
        run_conv(321, 3, 2, 1);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 3) == 0);
            valor = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                                : 10'($urandom_range(0, 1023));
        end
        rst = 1'b0; start = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
